// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and defaults for the register-file writeback unit.
package wb_pkg;

    localparam int unsigned WB_DEPTH  = 4;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 4;

    // R15 is the PC; the register file drives it externally.
    localparam logic [WB_ADDR_W-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// Writeback request FIFO; also presents its contents oldest-first so the
// parent can scan pending destinations for hazards and forwarding.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  wb_req_t                      push_req,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             entry_valid,
    output wb_req_t [DEPTH-1:0]          entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    wb_req_t            mem_q [DEPTH];
    wb_req_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry k is the k-th oldest; pointer arithmetic wraps modulo DEPTH.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k]     = mem_q[rd_ptr_q + PTR_W'(k)];
            entry_valid[k] = (CNT_W'(k) < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-side initiator with RAW hazard reporting.
// Optional macro WB_FORWARD_EN enables data forwarding on the fwd ports.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_data,
    output logic                         wr_enable,
    output logic [ADDR_W-1:0]            A3,
    output logic [DATA_W-1:0]            WD3,
    input  logic [ADDR_W-1:0]            chk_a1,
    input  logic [ADDR_W-1:0]            chk_a2,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic                         fwd1_valid,
    output logic [DATA_W-1:0]            fwd1_data,
    output logic                         fwd2_valid,
    output logic [DATA_W-1:0]            fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop_err
);

    logic                run_q, run_d;
    logic                wr_enable_q, wr_enable_d;
    logic [ADDR_W-1:0]   a3_q, a3_d;
    logic [DATA_W-1:0]   wd3_q, wd3_d;
    logic                drop_err_q, drop_err_d;

    logic                push;
    logic                is_pc;
    logic                enq;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    wb_req_t             enq_req;
    wb_req_t             head;
    logic [DEPTH-1:0]    entry_valid;
    wb_req_t [DEPTH-1:0] entries;

    // A pending write to chk exists in the queue or on the write port.
    function automatic logic pending_hit(
        input logic [ADDR_W-1:0]    chk,
        input logic                 we,
        input logic [ADDR_W-1:0]    a3,
        input logic [DEPTH-1:0]     vld,
        input wb_req_t [DEPTH-1:0]  ents
    );
        logic h;
        h = we && (a3 == chk);
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && (ents[k].addr == chk)) begin
                h = 1'b1;
            end
        end
        return h && (chk != ADDR_W'(PC_REG));
    endfunction

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (enq),
        .pop         (pop),
        .push_req    (enq_req),
        .head        (head),
        .count       (count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    // Ready depends only on registered state; run_q holds it low through reset.
    assign req_ready = run_q && !fifo_full;

    always_comb begin
        push          = req_valid && req_ready;
        is_pc         = (req_addr == ADDR_W'(PC_REG));
        enq           = push && !is_pc;
        enq_req.addr  = req_addr;
        enq_req.data  = req_data;
        pop           = !fifo_empty;
        run_d         = 1'b1;
        wr_enable_d   = pop;
        a3_d          = a3_q;
        wd3_d         = wd3_q;
        drop_err_d    = drop_err_q || (push && is_pc);
        if (pop) begin
            a3_d  = head.addr;
            wd3_d = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q       <= 1'b0;
            wr_enable_q <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            run_q       <= run_d;
            wr_enable_q <= wr_enable_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign wr_enable = wr_enable_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign drop_err  = drop_err_q;

    assign hazard1 = pending_hit(chk_a1, wr_enable_q, a3_q, entry_valid, entries);
    assign hazard2 = pending_hit(chk_a2, wr_enable_q, a3_q, entry_valid, entries);

`ifdef WB_FORWARD_EN
    // Youngest match wins: scan in-flight first, then queue oldest to newest.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [ADDR_W-1:0]    chk,
        input logic                 we,
        input logic [ADDR_W-1:0]    a3,
        input logic [DATA_W-1:0]    wd3,
        input logic [DEPTH-1:0]     vld,
        input wb_req_t [DEPTH-1:0]  ents
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (we && (a3 == chk)) begin
            r = wd3;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && (ents[k].addr == chk)) begin
                r = ents[k].data;
            end
        end
        return r;
    endfunction

    assign fwd1_valid = hazard1;
    assign fwd2_valid = hazard2;
    assign fwd1_data  = hazard1 ? fwd_pick(chk_a1, wr_enable_q, a3_q, wd3_q, entry_valid, entries) : '0;
    assign fwd2_data  = hazard2 ? fwd_pick(chk_a2, wr_enable_q, a3_q, wd3_q, entry_valid, entries) : '0;
`else
    logic unused_entry_data;

    always_comb begin
        unused_entry_data = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            unused_entry_data = unused_entry_data ^ (^entries[k].data);
        end
    end

    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit against a queue-based model.
// Forwarding expectations follow WB_FORWARD_EN.
module tb_reg_writeback_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr;
    logic [31:0] req_data;
    logic        wr_enable;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [3:0]  chk_a1;
    logic [3:0]  chk_a2;
    logic        hazard1;
    logic        hazard2;
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;
    logic [2:0]  count;
    logic        drop_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_run = 1'b0;
    logic        m_we  = 1'b0;
    logic [3:0]  m_a3  = '0;
    logic [31:0] m_wd3 = '0;
    logic        m_drop = 1'b0;
    logic        m_acc = 1'b0;

    reg_writeback_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .wr_enable  (wr_enable),
        .A3         (A3),
        .WD3        (WD3),
        .chk_a1     (chk_a1),
        .chk_a2     (chk_a2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .fwd1_valid (fwd1_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_valid (fwd2_valid),
        .fwd2_data  (fwd2_data),
        .count      (count),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hazard(input logic [3:0] c);
        logic h;
        h = m_we && (m_a3 == c);
        foreach (mq[i]) if (mq[i].addr == c) h = 1'b1;
        return h && (c != 4'd15);
    endfunction

    function automatic logic [31:0] m_fwd(input logic [3:0] c);
        logic [31:0] r;
        r = '0;
        if (m_hazard(c)) begin
            if (m_we && (m_a3 == c)) r = m_wd3;
            foreach (mq[i]) if (mq[i].addr == c) r = mq[i].data;
        end
        return r;
    endfunction

    // One clock: drive after negedge, compare against model, then advance model.
    task automatic cycle(input logic rst_v, input logic v, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] c1,
                         input logic [3:0] c2, input bit do_chk);
        logic m_ready;
        @(negedge clk);
        reset = rst_v; req_valid = v; req_addr = a; req_data = d;
        chk_a1 = c1; chk_a2 = c2;
        #1;
        m_ready = m_run && (mq.size() < DEPTH);
        if (do_chk) begin
            chk("wr_enable", 32'(wr_enable), 32'(m_we));
            chk("A3", 32'(A3), 32'(m_a3));
            chk("WD3", WD3, m_wd3);
            chk("count", 32'(count), 32'(mq.size()));
            chk("drop_err", 32'(drop_err), 32'(m_drop));
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("hazard1", 32'(hazard1), 32'(m_hazard(c1)));
            chk("hazard2", 32'(hazard2), 32'(m_hazard(c2)));
`ifdef WB_FORWARD_EN
            chk("fwd1_valid", 32'(fwd1_valid), 32'(m_hazard(c1)));
            chk("fwd2_valid", 32'(fwd2_valid), 32'(m_hazard(c2)));
            chk("fwd1_data", fwd1_data, m_fwd(c1));
            chk("fwd2_data", fwd2_data, m_fwd(c2));
`else
            chk("fwd1_valid", 32'(fwd1_valid), 32'd0);
            chk("fwd2_valid", 32'(fwd2_valid), 32'd0);
            chk("fwd1_data", fwd1_data, 32'd0);
            chk("fwd2_data", fwd2_data, 32'd0);
`endif
        end
        @(posedge clk);
        if (!rst_v) begin
            mq.delete();
            m_run = 1'b0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0;
            m_drop = 1'b0; m_acc = 1'b0;
        end else begin
            m_acc = v && m_ready;
            if (mq.size() > 0) begin
                m_we  = 1'b1;
                m_a3  = mq[0].addr;
                m_wd3 = mq[0].data;
                void'(mq.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (m_acc) begin
                if (a == 4'd15) m_drop = 1'b1;
                else            mq.push_back('{a, d});
            end
            m_run = 1'b1;
        end
    endtask

    initial begin
        int sent;
        int budget;
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        chk_a1 = '0; chk_a2 = '0;

        // Reset for two cycles, then release.
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        #2;
        chk("rst_wr_enable", 32'(wr_enable), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Single write, one-cycle latency, one-cycle pulse.
        cycle(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd0, 1'b1);
        #2;
        chk("single_not_bypassed", 32'(wr_enable), 32'd0);
        cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd3, 4'd0, 1'b1);
        #2;
        chk("single_we", 32'(wr_enable), 32'd1);
        chk("single_a3", 32'(A3), 32'd3);
        chk("single_wd3", WD3, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd3, 4'd0, 1'b1);
        #2;
        chk("single_pulse_end", 32'(wr_enable), 32'd0);
        chk("single_wd3_hold", WD3, 32'hDEADBEEF);

        // Back-to-back pushes of addr 1..5 with valid held.
        sent = 0; budget = 0;
        while (sent < 5 && budget < 50) begin
            cycle(1'b1, 1'b1, 4'(sent + 1), 32'h100 + 32'(sent), 4'(sent), 4'(sent + 1), 1'b1);
            if (m_acc) sent++;
            budget++;
        end
        chk("fill_all_accepted", 32'(sent), 32'd5);
        repeat (4) cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd5, 4'd4, 1'b1);

        // R15 is dropped and flagged sticky; the next write proceeds.
        cycle(1'b1, 1'b1, 4'd15, 32'h1234, 4'd15, 4'd2, 1'b1);
        cycle(1'b1, 1'b1, 4'd2, 32'h2222, 4'd15, 4'd2, 1'b1);
        #2;
        chk("r15_drop_err", 32'(drop_err), 32'd1);
        chk("r15_no_write", 32'(wr_enable), 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd2, 4'd15, 1'b1);

        // Hazard on a queued then in-flight address.
        cycle(1'b1, 1'b1, 4'd7, 32'h77, 4'd7, 4'd8, 1'b1);
        #2;
        chk("haz_queued_a1", 32'(hazard1), 32'd1);
        chk("haz_queued_a2", 32'(hazard2), 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd7, 4'd8, 1'b1);
        cycle(1'b1, 1'b1, 4'd15, 32'h5, 4'd15, 4'd7, 1'b1);
        #2;
        chk("haz_pc_never", 32'(hazard1), 32'd0);

        // Same destination twice: youngest data is forwarded.
        cycle(1'b1, 1'b1, 4'd5, 32'h11, 4'd5, 4'd6, 1'b1);
        cycle(1'b1, 1'b1, 4'd5, 32'h22, 4'd5, 4'd6, 1'b1);
        #2;
`ifdef WB_FORWARD_EN
        chk("fwd_youngest_valid", 32'(fwd1_valid), 32'd1);
        chk("fwd_youngest_data", fwd1_data, 32'h22);
`else
        chk("fwd_tied_valid", 32'(fwd1_valid), 32'd0);
        chk("fwd_tied_data", fwd1_data, 32'd0);
`endif
        repeat (3) cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd5, 4'd6, 1'b1);

        // Reset in the middle of a stream of writes.
        cycle(1'b1, 1'b1, 4'd9, 32'h99, 4'd9, 4'd10, 1'b1);
        cycle(1'b1, 1'b1, 4'd10, 32'hAA, 4'd9, 4'd10, 1'b1);
        cycle(1'b1, 1'b1, 4'd11, 32'hBB, 4'd9, 4'd11, 1'b1);
        cycle(1'b0, 1'b1, 4'd12, 32'hCC, 4'd11, 4'd12, 1'b1);
        #2;
        chk("midrst_we", 32'(wr_enable), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        repeat (4) cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd11, 4'd12, 1'b1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end
        repeat (3) cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 4'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
